// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: field addresses, default
// field limits and the time-setting state type.
package clock_pkg;

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;
    localparam logic [1:0] ADDR_HOUR = 2'b10;
    localparam logic [1:0] ADDR_NONE = 2'b11;

    localparam int DEF_SEC_MAX  = 59;
    localparam int DEF_MIN_MAX  = 59;
    localparam int DEF_HOUR_MAX = 23;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_HOURS,
        ST_SET_MINUTES,
        ST_SET_SECONDS
    } state_t;

    function automatic logic [1:0] field_addr(input state_t s);
        case (s)
            ST_SET_HOURS:   field_addr = ADDR_HOUR;
            ST_SET_MINUTES: field_addr = ADDR_MIN;
            ST_SET_SECONDS: field_addr = ADDR_SEC;
            default:        field_addr = ADDR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wrap_updown.sv
// Combinational +/-1 over 0..max with wrap; anything above max is pulled
// back into range (to 0 going up, to max going down).
module wrap_updown #(
    parameter int W = 6
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] max,
    input  logic         up,
    output logic [W-1:0] result
);

    always_comb begin
        result = value;
        if (up)
            result = (value >= max) ? '0 : value + 1'b1;
        else
            result = (value == '0 || value > max) ? max : value - 1'b1;
    end

endmodule

// File: rtl/time_set_ctrl.sv
// User time-setting controller: walks hours/minutes/seconds edit fields,
// freezes timekeeping while editing and drives the counters' load bus.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX  = DEF_HOUR_MAX,
    parameter int MIN_MAX   = DEF_MIN_MAX,
    parameter int SEC_MAX   = DEF_SEC_MAX,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_seconds,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_hours,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_in,
    output logic       time_hold,
    output logic       set_active,
    output logic       blink
);

    localparam logic [5:0] HMAX    = 6'(HOUR_MAX);
    localparam logic [5:0] MMAX    = 6'(MIN_MAX);
    localparam logic [5:0] SMAX    = 6'(SEC_MAX);
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

    state_t     state, mode_next;
    logic [5:0] edit, tcnt;
    logic [5:0] field_max, step_val, entry_val;

    always_comb begin
        mode_next = ST_RUN;
        entry_val = edit;
        field_max = '0;
        case (state)
            ST_RUN: begin
                mode_next = ST_SET_HOURS;
                entry_val = cur_hours;
            end
            ST_SET_HOURS: begin
                mode_next = ST_SET_MINUTES;
                entry_val = cur_minutes;
                field_max = HMAX;
            end
            ST_SET_MINUTES: begin
                mode_next = ST_SET_SECONDS;
                entry_val = cur_seconds;
                field_max = MMAX;
            end
            ST_SET_SECONDS: begin
                mode_next = ST_RUN;
                field_max = SMAX;
            end
            default: ;
        endcase
    end

    wrap_updown #(.W(6)) u_wrap (
        .value  (edit),
        .max    (field_max),
        .up     (btn_inc),
        .result (step_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            load       <= 1'b0;
            addrs      <= ADDR_NONE;
            data_in    <= '0;
            time_hold  <= 1'b0;
            set_active <= 1'b0;
            blink      <= 1'b0;
            tcnt       <= '0;
            edit       <= '0;
        end else begin
            load <= 1'b0;
            // mode outranks inc/dec; entering a field captures the live value
            if (btn_mode) begin
                state      <= mode_next;
                edit       <= entry_val;
                addrs      <= field_addr(mode_next);
                time_hold  <= (mode_next != ST_RUN);
                set_active <= (mode_next != ST_RUN);
                blink      <= 1'b0;
                tcnt       <= '0;
            end else if (state != ST_RUN) begin
                if (btn_inc ^ btn_dec) begin
                    edit    <= step_val;
                    data_in <= step_val;
                    load    <= 1'b1;
                    blink   <= 1'b1;
                    tcnt    <= '0;
                end else if (tick_1hz) begin
                    if (tcnt >= TO_LAST) begin
                        state      <= ST_RUN;
                        addrs      <= ADDR_NONE;
                        time_hold  <= 1'b0;
                        set_active <= 1'b0;
                        blink      <= 1'b0;
                        tcnt       <= '0;
                    end else begin
                        tcnt  <= tcnt + 1'b1;
                        blink <= ~blink;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random presses against a
// field-level reference model; loads are matched through a scoreboard queue.
module tb_time_set_ctrl;

    localparam int TO = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [5:0] cur_seconds = '0, cur_minutes = '0, cur_hours = '0;
    logic       load, time_hold, set_active, blink;
    logic [1:0] addrs;
    logic [5:0] data_in;

    int total = 0, bad = 0;

    typedef struct { int addr; int data; } ld_t;
    ld_t exp_q[$];

    // reference: md 0=run,1=hours,2=minutes,3=seconds
    int md = 0, ed = 0, tc = 0;
    bit bl = 0, exp_load = 0;

    time_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_seconds(cur_seconds), .cur_minutes(cur_minutes), .cur_hours(cur_hours),
        .load(load), .addrs(addrs), .data_in(data_in),
        .time_hold(time_hold), .set_active(set_active), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int fmax(input int m);
        return (m == 1) ? 23 : 59;
    endfunction

    function automatic int fcur(input int m);
        return (m == 1) ? int'(cur_hours) : (m == 2) ? int'(cur_minutes) : int'(cur_seconds);
    endfunction

    task automatic model_step();
        ld_t e;
        exp_load = 0;
        if (btn_mode) begin
            md = (md + 1) % 4;
            if (md != 0) ed = fcur(md);
            tc = 0;
            bl = 0;
        end else if (md != 0) begin
            if (btn_inc != btn_dec) begin
                if (btn_inc) ed = (ed >= fmax(md)) ? 0 : ed + 1;
                else         ed = (ed == 0 || ed > fmax(md)) ? fmax(md) : ed - 1;
                e.addr = 3 - md;
                e.data = ed;
                exp_q.push_back(e);
                exp_load = 1;
                tc = 0;
                bl = 1;
            end else if (tick_1hz) begin
                tc++;
                if (tc == TO) begin
                    md = 0; tc = 0; bl = 0;
                end else begin
                    bl = !bl;
                end
            end
        end
    endtask

    task automatic step(input bit m, input bit i, input bit d, input bit t, input string tag);
        btn_mode = m; btn_inc = i; btn_dec = d; tick_1hz = t;
        model_step();
        @(posedge clk); #1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
        chk({tag, ".load"}, load, exp_load);
        chk({tag, ".addrs"}, addrs, (md == 0) ? 3 : 3 - md);
        chk({tag, ".time_hold"}, time_hold, md != 0);
        chk({tag, ".set_active"}, set_active, md != 0);
        chk({tag, ".blink"}, blink, bl);
    endtask

    // scoreboard monitor: every load strobe must match the oldest expectation
    always @(negedge clk) begin
        ld_t e;
        if (reset && load) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL load_unexpected actual addrs=%0d data=%0d required none", addrs, data_in);
            end else begin
                e = exp_q.pop_front();
                chk("mon.addr", addrs, e.addr);
                chk("mon.data", data_in, e.data);
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #10;
        chk("rst.load", load, 0);
        chk("rst.addrs", addrs, 3);
        chk("rst.data_in", data_in, 0);
        chk("rst.time_hold", time_hold, 0);
        chk("rst.blink", blink, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // hours wrap 22 -> 23 -> 0
        cur_hours = 6'd22;
        step(1, 0, 0, 0, "h_enter");
        step(0, 1, 0, 0, "h_inc1");
        chk("h_inc1.data", data_in, 23);
        step(0, 1, 0, 0, "h_inc2");
        chk("h_inc2.data", data_in, 0);

        // minutes: dec from 0, then simultaneous inc/dec
        cur_minutes = 6'd0;
        step(1, 0, 0, 0, "m_enter");
        step(0, 0, 1, 0, "m_dec");
        chk("m_dec.data", data_in, 59);
        step(0, 1, 1, 0, "m_both");
        step(1, 1, 0, 0, "s_mode_wins");
        step(1, 0, 0, 0, "s_exit");
        chk("walk.time_hold", time_hold, 0);

        // timeout with no buttons
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, "to_walk");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, "to_tick");
        chk("to.run", set_active, 0);

        // timeout restarted by inc on the 2nd tick
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, "to2_walk");
        step(0, 0, 0, 1, "to2_t1");
        step(0, 1, 0, 1, "to2_inc");
        step(0, 0, 0, 1, "to2_t2");
        step(0, 0, 0, 1, "to2_t3");
        chk("to2.still_set", set_active, 1);
        step(0, 0, 0, 1, "to2_t4");
        chk("to2.run", set_active, 0);

        // out-of-range entry value normalisation
        cur_seconds = 6'd62;
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, "oor_walk");
        step(0, 1, 0, 0, "oor_inc");
        chk("oor_inc.data", data_in, 0);
        step(1, 0, 0, 0, "oor_exit");
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, "oor_walk2");
        step(0, 0, 1, 0, "oor_dec");
        chk("oor_dec.data", data_in, 59);
        step(1, 0, 0, 0, "oor_exit2");

        // asynchronous reset in the middle of SET_MINUTES
        step(1, 0, 0, 0, "r_h");
        step(1, 0, 0, 0, "r_m");
        reset = 1'b0;
        #1;
        chk("midrst.load", load, 0);
        chk("midrst.addrs", addrs, 3);
        chk("midrst.time_hold", time_hold, 0);
        chk("midrst.set_active", set_active, 0);
        md = 0; ed = 0; tc = 0; bl = 0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, "post_rst");

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cur_hours   = 6'($urandom_range(0, 63));
            cur_minutes = 6'($urandom_range(0, 63));
            cur_seconds = 6'($urandom_range(0, 63));
            step($urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, "rnd");
        end
        step(0, 0, 0, 0, "drain");
        @(negedge clk);
        chk("q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User time-setting controller; sits directly upstream of the seconds/minutes/hours counters and drives their shared load, addrs and data_in bus.
- Takes debounced single-cycle button pulses (mode, inc, dec) and lets the user step through fields in the order hours, minutes, seconds.
- Freezes timekeeping while a field is being edited.
- Returns to run mode when the user finishes, or after an inactivity timeout.

Parameters:
- HOUR_MAX, 23, largest legal hours value (wrap point).
- MIN_MAX, 59, largest legal minutes value.
- SEC_MAX, 59, largest legal seconds value.
- TIMEOUT_S, 30, number of tick_1hz pulses without a button press before edit mode is abandoned; legal range 1..63.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick_1hz  input  1  raw one-cycle time-base pulse, ungated by this block.
- btn_mode  input  1  debounced one-cycle pulse, advance field.
- btn_inc  input  1  debounced one-cycle pulse, increment field.
- btn_dec  input  1  debounced one-cycle pulse, decrement field.
- cur_seconds  input  6  live seconds counter value.
- cur_minutes  input  6  live minutes counter value.
- cur_hours  input  6  live hours counter value.
- load  output  1  one-cycle load strobe to the counters.
- addrs  output  2  field select: 00 seconds, 01 minutes, 10 hours, 11 none.
- data_in  output  6  value to load.
- time_hold  output  1  high while editing; gates tc_time_base upstream of the counters.
- set_active  output  1  high in any SET state.
- blink  output  1  display blink phase for the edited field.

Behaviour:
- Reset values (asynchronous, reset=0): state RUN, load=0, addrs=11, data_in=0, time_hold=0, set_active=0, blink=0, timeout counter=0, edit register=0.
- State machine: RUN, SET_HOURS, SET_MINUTES, SET_SECONDS.
- RUN + btn_mode → SET_HOURS.
- SET_HOURS + btn_mode → SET_MINUTES.
- SET_MINUTES + btn_mode → SET_SECONDS.
- SET_SECONDS + btn_mode → RUN.
- Any SET state + timeout → RUN.
- On entry to each SET state: the 6-bit edit register is loaded from the matching cur_* input in the same clock edge as the state change.
- addrs is registered: 10 / 01 / 00 in SET_HOURS / SET_MINUTES / SET_SECONDS, and 11 in RUN.
- Editing (SET states only):
  - btn_inc: edit = (edit ≥ MAX) ? 0 : edit+1.
  - btn_dec: edit = (edit == 0 or edit > MAX) ? MAX : edit-1. MAX is the field's parameter.
  - Next cycle: load=1 for exactly one cycle, data_in = new edit value, addrs = current field. Latency is 1 cycle from the button pulse to the load strobe.
- Ignored button inputs:
  - btn_inc and btn_dec in the same cycle: both ignored, no load.
  - btn_mode in the same cycle as inc/dec: mode wins, inc/dec dropped.
  - inc/dec in RUN: ignored.
- Out-of-range cur_* value on field entry (e.g. 62): kept until the first inc/dec, then normalised by the rules above. No load is issued on entry.
- time_hold and set_active are 1 in every SET state. Both drop to 0 in the cycle the state becomes RUN.
- Timeout:
  - The counter clears on field entry and on any accepted button press.
  - It increments on tick_1hz while in a SET state.
  - When the counter reaches TIMEOUT_S, go to RUN, issue no load, and keep all values already loaded.
  - Button press and tick in the same cycle: the button wins and the counter clears.
- blink:
  - Toggles on each tick_1hz in SET states.
  - Forced to 0 in RUN and on every field entry.
  - Forced to 1 for the cycle after any accepted inc/dec, so the value is visible while adjusting.
- load is never asserted in RUN and never with addrs=11.
- Reset mid-edit: immediate return to reset values. Values already loaded into the counters stay loaded; the counter reset is separate.

Decomposition:
- Shared package clock_pkg:
  - Field address constants ADDR_SEC=2'b00, ADDR_MIN=2'b01, ADDR_HOUR=2'b10, ADDR_NONE=2'b11.
  - State enum type for RUN/SET_HOURS/SET_MINUTES/SET_SECONDS.
  - Default limit constants 59/59/23.
- One natural sub-module: wrap_updown. Combinational ±1 with 0..MAX wrap and the out-of-range normalisation rule; reusable by the minutes and hours counters.

Test Plan:
- Reset=0 mid-SET_MINUTES → within the same cycle: load=0, addrs=11, time_hold=0, state RUN; release reset → idle with no spurious load.
- cur_hours=22, mode, inc, inc → after entry addrs=10 and time_hold=1; first inc gives load pulse data_in=23; second inc gives load pulse data_in=0.
- SET_MINUTES with cur_minutes=0, dec → one load pulse, addrs=01, data_in=59; inc and dec in the same cycle → no load.
- Full cycle: mode ×4 → states HOURS, MINUTES, SECONDS, RUN; time_hold falls on the 4th mode; no load during the walk without inc/dec.
- TIMEOUT_S=3, enter SET_SECONDS, send 3 tick_1hz with no buttons → RUN after the 3rd tick, no load; repeat with inc on the 2nd tick → counter restarts and RUN follows 3 ticks after the inc.
- cur_seconds=62 on entry, inc → data_in=0; repeat with dec → data_in=59. Check blink=1 the cycle after each inc/dec.
